// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - multi-cycle multiply/divide unit owning the HI/LO register pair
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   start    request strobe, qualifies mdu_op (ignored while busy)
//   mdu_op   1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, others NOP
//   rs, rt   operands (rs also carries MTHI/MTLO data)
//   busy     multi-cycle operation in flight
//   hi_out   current HI register
//   lo_out   current LO register

module mdu_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       mdu_op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             busy,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;

  localparam logic [CNT_W-1:0] MUL_N   = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N   = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
  logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
  logic             pend_wr_q, pend_wr_d;

  // Results are computed from rs/rt at the accept edge and parked in the
  // pending registers; that snapshot is the operand latch, so later rs/rt
  // changes cannot affect the outcome.
  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs_s, b_div_u;
  logic [WIDTH-1:0]   uq_s, ur_s, q_s, r_s;
  logic [WIDTH-1:0]   q_u, r_u;
  logic               div_zero;

  always_comb begin
    // Low 2*WIDTH bits of the product of sign-extended operands equal the
    // signed product, so one unsigned multiplier form serves both.
    prod_s = {{WIDTH{rs[WIDTH-1]}}, rs} * {{WIDTH{rt[WIDTH-1]}}, rt};
    prod_u = {{WIDTH{1'b0}}, rs} * {{WIDTH{1'b0}}, rt};

    div_zero = (rt == '0);

    // Signed divide via magnitudes. The magnitude of the most-negative value
    // is representable as unsigned, so most-negative / -1 naturally yields
    // quotient = most-negative, remainder = 0.
    a_neg   = rs[WIDTH-1];
    b_neg   = rt[WIDTH-1];
    a_abs   = a_neg ? (~rs + WIDTH'(1)) : rs;
    b_abs_s = div_zero ? WIDTH'(1) : (b_neg ? (~rt + WIDTH'(1)) : rt);
    uq_s    = a_abs / b_abs_s;
    ur_s    = a_abs % b_abs_s;
    q_s     = (a_neg ^ b_neg) ? (~uq_s + WIDTH'(1)) : uq_s;
    r_s     = a_neg ? (~ur_s + WIDTH'(1)) : ur_s;

    // Divisor forced to 1 on zero only to keep the datapath defined; the
    // result is discarded in that case.
    b_div_u = div_zero ? WIDTH'(1) : rt;
    q_u     = rs / b_div_u;
    r_u     = rs % b_div_u;
  end

  assign busy   = (cnt_q != '0);
  assign hi_out = hi_q;
  assign lo_out = lo_q;

  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;

    if (busy) begin
      if (cnt_q == CNT_ONE) begin
        cnt_d = '0;
        if (pend_wr_q) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
        pend_wr_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end else if (start) begin
      unique case (mdu_op)
        OP_MULT: begin
          cnt_d     = MUL_N;
          pend_hi_d = prod_s[2*WIDTH-1:WIDTH];
          pend_lo_d = prod_s[WIDTH-1:0];
          pend_wr_d = 1'b1;
        end
        OP_MULTU: begin
          cnt_d     = MUL_N;
          pend_hi_d = prod_u[2*WIDTH-1:WIDTH];
          pend_lo_d = prod_u[WIDTH-1:0];
          pend_wr_d = 1'b1;
        end
        OP_DIV: begin
          cnt_d     = DIV_N;
          pend_hi_d = r_s;
          pend_lo_d = q_s;
          pend_wr_d = !div_zero;
        end
        OP_DIVU: begin
          cnt_d     = DIV_N;
          pend_hi_d = r_u;
          pend_lo_d = q_u;
          pend_wr_d = !div_zero;
        end
        OP_MTHI: hi_d = rs;
        OP_MTLO: lo_d = rs;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

endmodule
